// File: rtl/core_inst_sequencer_if.sv
// Host/core-facing signal bundle of core_inst_sequencer.
// SEQ_PERF_CNT_EN adds the perf_busy/perf_stall counters.
interface core_inst_sequencer_if #(
    parameter int addr_bw = 11
);
    logic               start;
    logic               ofifo_valid;
    logic [addr_bw-1:0] acc_addr;
    logic               acc_addr_valid;
    logic               acc_addr_rd;
    logic [46:0]        inst;
    logic               acc_clr;
    logic               out_valid;
    logic               busy;
    logic               done;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]        perf_busy;
    logic [31:0]        perf_stall;
`endif

    modport master (
        input  start, ofifo_valid, acc_addr, acc_addr_valid,
        output acc_addr_rd, inst, acc_clr, out_valid, busy, done
`ifdef SEQ_PERF_CNT_EN
        , output perf_busy, perf_stall
`endif
    );

    modport slave (
        output start, ofifo_valid, acc_addr, acc_addr_valid,
        input  acc_addr_rd, inst, acc_clr, out_valid, busy, done
`ifdef SEQ_PERF_CNT_EN
        , input perf_busy, perf_stall
`endif
    );
endinterface

// File: rtl/core_inst_sequencer.sv
// Generates the 47-bit core instruction stream for one conv tile.
// Optional macro SEQ_PERF_CNT_EN adds busy/stall perf counters.
module core_inst_sequencer #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int len_nij  = 36,
    parameter int len_onij = 16,
    parameter int len_kij  = 9,
    parameter int addr_bw  = 11,
    parameter int gap      = 10
) (
    input  logic clk,
    input  logic reset,
    core_inst_sequencer_if.master io
);
    localparam int TW = $clog2(len_nij + row + col + gap + col + 2);
    localparam int KW = $clog2(len_kij + 1);
    localparam int WW = $clog2(len_nij + 1);
    localparam int OW = $clog2(len_onij + 1);
    localparam int JW = $clog2(len_kij + 1);

    localparam logic [TW-1:0] T_WF = TW'(col);
    localparam logic [TW-1:0] T_KL = TW'(row + col - 2);
    localparam logic [TW-1:0] T_GP = TW'(gap - 1);
    localparam logic [TW-1:0] T_XF = TW'(len_nij - 1);
    localparam logic [TW-1:0] T_EX = TW'(len_nij + row + col - 2);
    localparam logic [WW-1:0] W_LAST = WW'(len_nij - 1);
    localparam logic [KW-1:0] K_LAST = KW'(len_kij - 1);
    localparam logic [OW-1:0] O_LAST = OW'(len_onij - 1);
    localparam logic [JW-1:0] J_LAST = JW'(len_kij - 1);

    localparam logic [46:0] IDLE_INST = 47'h6001_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_WFILL, S_KLOAD, S_GAP, S_XFILL, S_EXEC,
        S_DRAIN, S_ACC_CLR, S_ACC_RD, S_ACC_END, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [KW-1:0] kij_q, kij_d;
    logic [WW-1:0] w_q, w_d;
    logic [OW-1:0] onij_q, onij_d;
    logic [JW-1:0] j_q, j_d;
    logic rd_q, rd_d;

    logic [46:0] inst_q, inst_d;
    logic rdstb_q, rdstb_d;
    logic clr_q, clr_d;
    logic ov_q, ov_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic [addr_bw-1:0] waddr, paddr, xaddr;

    assign waddr = addr_bw'(kij_q) * addr_bw'(col) + addr_bw'(t_q);
    assign paddr = addr_bw'(kij_q) * addr_bw'(len_nij) + addr_bw'(w_q);
    assign xaddr = addr_bw'(t_q);

    // Phase sequencing and the instruction word for the next cycle
    always_comb begin
        state_d = state_q;
        t_d     = t_q + TW'(1);
        kij_d   = kij_q;
        w_d     = w_q;
        onij_d  = onij_q;
        j_d     = j_q;
        rd_d    = 1'b0;
        inst_d  = IDLE_INST;
        rdstb_d = 1'b0;
        clr_d   = 1'b0;
        ov_d    = 1'b0;
        done_d  = 1'b0;
        busy_d  = (state_q != S_IDLE);
        // acc follows each issued psum read by one cycle
        inst_d[33] = rd_q;
        unique case (state_q)
            S_IDLE: begin
                t_d = '0;
                if (io.start) begin
                    state_d = S_WFILL;
                    kij_d   = '0;
                    w_d     = '0;
                    onij_d  = '0;
                    j_d     = '0;
                end
            end
            S_WFILL: begin
                // last cycle only keeps ififo_wr up to capture data
                inst_d[5] = 1'b1;
                if (t_q != T_WF) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = 11'(waddr);
                end else begin
                    state_d = S_KLOAD;
                    t_d     = '0;
                end
            end
            S_KLOAD: begin
                inst_d[4] = 1'b1;
                inst_d[0] = 1'b1;
                if (t_q == T_KL) begin
                    state_d = S_GAP;
                    t_d     = '0;
                end
            end
            S_GAP: begin
                if (t_q == T_GP) begin
                    state_d = S_XFILL;
                    t_d     = '0;
                end
            end
            S_XFILL: begin
                inst_d[46]    = 1'b0;
                inst_d[44:34] = 11'(xaddr);
                inst_d[2]     = 1'b1;
                if (t_q == T_XF) begin
                    state_d = S_EXEC;
                    t_d     = '0;
                end
            end
            S_EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = (t_q != T_EX);
                if (t_q == T_EX) begin
                    state_d = S_DRAIN;
                    t_d     = '0;
                    w_d     = '0;
                end
            end
            S_DRAIN: begin
                t_d = '0;
                if (io.ofifo_valid) begin
                    inst_d[6]     = 1'b1;
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = 11'(paddr);
                    w_d           = w_q + WW'(1);
                    if (w_q == W_LAST) begin
                        w_d = '0;
                        if (kij_q == K_LAST) begin
                            state_d = S_ACC_CLR;
                        end else begin
                            state_d = S_WFILL;
                            kij_d   = kij_q + KW'(1);
                        end
                    end
                end
            end
            S_ACC_CLR: begin
                t_d     = '0;
                clr_d   = 1'b1;
                j_d     = '0;
                state_d = S_ACC_RD;
            end
            S_ACC_RD: begin
                t_d = '0;
                if (io.acc_addr_valid) begin
                    inst_d[32]    = 1'b0;
                    inst_d[30:20] = 11'(io.acc_addr);
                    rdstb_d       = 1'b1;
                    rd_d          = 1'b1;
                    j_d           = j_q + JW'(1);
                    if (j_q == J_LAST) begin
                        state_d = S_ACC_END;
                    end
                end
            end
            S_ACC_END: begin
                // first cycle carries the last acc, second emits the pixel
                if (t_q != '0) begin
                    ov_d = 1'b1;
                    if (onij_q == O_LAST) begin
                        state_d = S_DONE;
                        onij_d  = '0;
                    end else begin
                        state_d = S_ACC_CLR;
                        onij_d  = onij_q + OW'(1);
                    end
                end
            end
            S_DONE: begin
                t_d     = '0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            kij_q   <= '0;
            w_q     <= '0;
            onij_q  <= '0;
            j_q     <= '0;
            rd_q    <= 1'b0;
            inst_q  <= IDLE_INST;
            rdstb_q <= 1'b0;
            clr_q   <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            kij_q   <= kij_d;
            w_q     <= w_d;
            onij_q  <= onij_d;
            j_q     <= j_d;
            rd_q    <= rd_d;
            inst_q  <= inst_d;
            rdstb_q <= rdstb_d;
            clr_q   <= clr_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign io.inst        = inst_q;
    assign io.acc_addr_rd = rdstb_q;
    assign io.acc_clr     = clr_q;
    assign io.out_valid   = ov_q;
    assign io.busy        = busy_q;
    assign io.done        = done_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] pbusy_q, pstall_q;
    logic        stall;

    assign stall = (state_q == S_DRAIN && !io.ofifo_valid) ||
                   (state_q == S_ACC_RD && !io.acc_addr_valid);

    // Saturating busy/stall counters, cleared by an accepted start
    always_ff @(posedge clk) begin
        if (reset || (state_q == S_IDLE && io.start)) begin
            pbusy_q  <= '0;
            pstall_q <= '0;
        end else begin
            if (state_q != S_IDLE && pbusy_q != '1) begin
                pbusy_q <= pbusy_q + 32'd1;
            end
            if (stall && pstall_q != '1) begin
                pstall_q <= pstall_q + 32'd1;
            end
        end
    end

    assign io.perf_busy  = pbusy_q;
    assign io.perf_stall = pstall_q;
`endif
endmodule

// File: tb/tb_core_inst_sequencer.sv
// Self-checking bench for core_inst_sequencer (default parameters).
// Also checks perf counters when SEQ_PERF_CNT_EN is defined.
module tb_core_inst_sequencer;
    localparam logic [46:0] IDLE_W = 47'h6001_800C_0000;
    localparam int MAXS = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    core_inst_sequencer_if #(.addr_bw(11)) io();

    core_inst_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.master)
    );

    // Expected outputs and stimulus per work slot of one tile
    logic [46:0] e_inst [MAXS];
    bit          e_rd   [MAXS];
    bit          e_clr  [MAXS];
    bit          e_ov   [MAXS];
    bit          e_done [MAXS];
    bit          s_ofv  [MAXS];
    bit          s_aav  [MAXS];
    logic [10:0] s_aa   [MAXS];
    int ms, nslots, nstall;
    int checks = 0;
    int errors = 0;

    task automatic push(input logic [46:0] w, input bit rd,
                        input bit clr, input bit ov, input bit dn);
        e_inst[ms] = w;
        e_rd[ms]   = rd;
        e_clr[ms]  = clr;
        e_ov[ms]   = ov;
        e_done[ms] = dn;
        ms++;
    endtask

    // Tile model: phase lists with their lengths and addresses
    task automatic build(input bit stalls);
        logic [46:0] w;
        int n, p;
        bit v, prev;
        ms = 0;
        nstall = 0;
        for (int s = 0; s < MAXS; s++) begin
            s_ofv[s] = stalls & s[0];
            s_aav[s] = stalls & s[1];
            s_aa[s]  = 11'(s * 37 + 5);
        end
        for (int k = 0; k < 9; k++) begin
            for (int t = 0; t < 8; t++) begin
                w = IDLE_W; w[19] = 1'b0; w[17:7] = 11'(k * 8 + t); w[5] = 1'b1;
                push(w, 0, 0, 0, 0);
            end
            w = IDLE_W; w[5] = 1'b1;
            push(w, 0, 0, 0, 0);
            repeat (15) begin
                w = IDLE_W; w[4] = 1'b1; w[0] = 1'b1;
                push(w, 0, 0, 0, 0);
            end
            repeat (10) push(IDLE_W, 0, 0, 0, 0);
            for (int t = 0; t < 36; t++) begin
                w = IDLE_W; w[46] = 1'b0; w[44:34] = 11'(t); w[2] = 1'b1;
                push(w, 0, 0, 0, 0);
            end
            for (int t = 0; t < 51; t++) begin
                w = IDLE_W; w[3] = 1'b1; w[1] = (t < 50);
                push(w, 0, 0, 0, 0);
            end
            n = 0;
            p = 0;
            while (n < 36) begin
                v = !stalls || (k == 2 ? (p % 2 == 0) : (p % 4 != 3));
                w = IDLE_W;
                if (v) begin
                    w[6] = 1'b1; w[32] = 1'b0; w[31] = 1'b0;
                    w[30:20] = 11'(k * 36 + n);
                    n++;
                end else begin
                    nstall++;
                end
                s_ofv[ms] = v;
                push(w, 0, 0, 0, 0);
                p++;
            end
        end
        for (int o = 0; o < 16; o++) begin
            push(IDLE_W, 0, 1, 0, 0);
            n = 0;
            p = 0;
            prev = 1'b0;
            while (n < 9) begin
                v = !stalls || o != 5 || !(p == 4 || p == 5);
                w = IDLE_W;
                w[33] = prev;
                if (v) begin
                    w[32] = 1'b0;
                    w[30:20] = s_aa[ms];
                    n++;
                end else begin
                    nstall++;
                end
                s_aav[ms] = v;
                push(w, v, 0, 0, 0);
                prev = v;
                p++;
            end
            w = IDLE_W; w[33] = prev;
            push(w, 0, 0, 0, 0);
            push(IDLE_W, 0, 0, 1, 0);
        end
        push(IDLE_W, 0, 0, 0, 1);
        nslots = ms;
    endtask

    function automatic logic [51:0] actual();
        return {io.inst, io.acc_addr_rd, io.acc_clr,
                io.out_valid, io.busy, io.done};
    endfunction

    task automatic cmp(input string nm, input logic [51:0] act,
                       input logic [51:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cmp32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Starts a tile and checks every slot against the model
    task automatic run(input int glitch, input int stop_at);
        @(negedge clk);
        io.start = 1'b1;
        for (int s = 0; s <= nslots && s < stop_at; s++) begin
            @(negedge clk);
            io.start          = (s == glitch);
            io.ofifo_valid    = s_ofv[s];
            io.acc_addr_valid = s_aav[s];
            io.acc_addr       = s_aa[s];
            @(posedge clk);
            #1;
            if (s == nslots)
                cmp($sformatf("post_slot%0d", s), actual(), {IDLE_W, 5'b0});
            else
                cmp($sformatf("slot%0d", s), actual(),
                    {e_inst[s], e_rd[s], e_clr[s], e_ov[s], 1'b1, e_done[s]});
        end
        io.start = 1'b0;
    endtask

    initial begin
        int nov;
        io.start          = 1'b0;
        io.ofifo_valid    = 1'b0;
        io.acc_addr_valid = 1'b0;
        io.acc_addr       = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_state", actual(), {IDLE_W, 5'b0});
        @(negedge clk);
        reset = 1'b0;

        // Tile 1: drain/acc stalls, ofifo_valid noise, start during KLOAD
        build(1'b1);
        run(12, MAXS);
`ifdef SEQ_PERF_CNT_EN
        cmp32("perf_busy_t1", io.perf_busy, 32'(nslots));
        cmp32("perf_stall_t1", io.perf_stall, 32'(nstall));
`endif

        // Tile 2: reset held 3 cycles mid-EXEC, start alongside reset
        build(1'b0);
        run(-1, 80);
        @(negedge clk);
        reset    = 1'b1;
        io.start = 1'b1;
        @(posedge clk);
        #1;
        cmp("reset_mid_exec", actual(), {IDLE_W, 5'b0});
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_hold", actual(), {IDLE_W, 5'b0});
`ifdef SEQ_PERF_CNT_EN
        cmp32("perf_busy_rst", io.perf_busy, 32'd0);
`endif
        @(negedge clk);
        reset    = 1'b0;
        io.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("idle_after_rst", actual(), {IDLE_W, 5'b0});

        // Tile 3: clean run; pin the model with hand-computed values
        build(1'b0);
        nov = 0;
        for (int s = 0; s < nslots; s++) nov += e_ov[s];
        cmp32("model_len", 32'(nslots), 32'd1606);
        cmp32("model_ov_count", 32'(nov), 32'd16);
        cmp32("model_slot0", 32'(e_inst[0][31:0]), 32'h8004_0020);
        cmp32("model_k3_a0", 32'(e_inst[471][17:7]), 32'd24);
        cmp32("model_k3_a7", 32'(e_inst[478][17:7]), 32'd31);
        cmp32("model_xfill0", 32'({e_inst[34][46], e_inst[34][2]}), 32'd1);
        cmp32("model_exec_end", 32'({e_inst[119][1], e_inst[120][1], e_inst[120][3]}), 32'd5);
        cmp32("model_k2_p0", 32'(e_inst[435][30:20]), 32'd72);
        cmp32("model_k2_p35", 32'(e_inst[470][30:20]), 32'd107);
        cmp32("model_pix0", 32'({e_clr[1413], e_inst[1423][33], e_ov[1424]}), 32'd7);
        cmp32("model_done", 32'(e_done[1605]), 32'd1);
        run(-1, MAXS);
`ifdef SEQ_PERF_CNT_EN
        cmp32("perf_busy_t3", io.perf_busy, 32'd1606);
        cmp32("perf_stall_t3", io.perf_stall, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
